// File: rtl/uc_broadcaster.sv
// uc_broadcaster: drains unit literals from the arbiter queue and broadcasts
// each one to every propagation engine, dropping repeats via a seen table.
module uc_broadcaster #(
    parameter int UC_LENGTH  = 1024,
    parameter int NUM_ENGINE = 4,
    parameter int CNT_W      = 16,
    localparam int LW        = $clog2(UC_LENGTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ucq_empty,
    input  logic [LW-1:0]         ucq2bc,
    output logic                  bc2ucq_pop,
    input  logic                  flush,
    output logic [LW-1:0]         bc2eng,
    output logic [NUM_ENGINE-1:0] bc2eng_valid,
    input  logic [NUM_ENGINE-1:0] eng2bc_ready,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      bcast_cnt,
    output logic [CNT_W-1:0]      dup_cnt
);

    localparam int IW = LW - 1;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [LW-1:0]          r_lit;
    logic [NUM_ENGINE-1:0]  r_pending;
    logic [UC_LENGTH-1:0][1:0] r_seen;
    logic [CNT_W-1:0]       r_bcast;
    logic [CNT_W-1:0]       r_dup;

    logic [IW-1:0]          w_idx;
    logic                   w_pol;
    logic                   w_idle;
    logic                   w_pop;
    logic                   w_dup;
    logic                   w_accept;
    logic                   w_drop;
    logic [NUM_ENGINE-1:0]  w_rem;
    logic                   w_fin;

    assign w_idx    = ucq2bc[IW-1:0];
    assign w_pol    = ucq2bc[LW-1];
    assign w_idle   = (r_state == S_IDLE);
    assign w_pop    = w_idle && !flush && !ucq_empty;
    assign w_dup    = r_seen[w_idx][w_pol];
    assign w_accept = w_pop && !w_dup;
    assign w_drop   = w_pop && w_dup;
    assign w_rem    = r_pending & ~eng2bc_ready;
    assign w_fin    = !w_idle && !flush && (w_rem == '0);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: flush always returns to IDLE
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: if (w_accept) w_next = S_SEND;
                S_SEND: if (w_rem == '0) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from state and current inputs
    always_comb begin
        bc2ucq_pop   = w_pop;
        busy         = !w_idle;
        done         = w_idle && ucq_empty;
        bc2eng       = r_lit;
        bc2eng_valid = w_idle ? '0 : r_pending;
        bcast_cnt    = r_bcast;
        dup_cnt      = r_dup;
    end

    // Literal, per-engine pending mask and seen table
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lit     <= '0;
            r_pending <= '0;
            r_seen    <= '0;
        end else if (flush) begin
            r_pending <= '0;
            r_seen    <= '0;
        end else if (w_accept) begin
            r_seen[w_idx][w_pol] <= 1'b1;
            r_lit                <= ucq2bc;
            r_pending            <= '1;
        end else if (!w_idle) begin
            r_pending <= w_rem;
        end
    end

    // Saturating statistics counters; flush suppresses both
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bcast <= '0;
            r_dup   <= '0;
        end else begin
            if (w_fin && (r_bcast != '1)) begin
                r_bcast <= r_bcast + CNT_W'(1);
            end
            if (w_drop && (r_dup != '1)) begin
                r_dup <= r_dup + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uc_broadcaster.sv
// tb_uc_broadcaster: scoreboard bench for uc_broadcaster; a queue model
// feeds literals and a monitor matches each broadcast against expectations.
module tb_uc_broadcaster;

    localparam int LW = 11;
    localparam int NE = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ucq_empty = 1'b1;
    logic [LW-1:0] ucq2bc = '0;
    logic          bc2ucq_pop;
    logic          flush = 1'b0;
    logic [LW-1:0] bc2eng;
    logic [NE-1:0] bc2eng_valid;
    logic [NE-1:0] eng2bc_ready = '1;
    logic          busy;
    logic          done;
    logic [CW-1:0] bcast_cnt;
    logic [CW-1:0] dup_cnt;

    int checks = 0;
    int failures = 0;

    logic [LW-1:0] src_q[$];
    logic [LW-1:0] exp_q[$];
    bit            tb_seen [0:2047];
    int            exp_bcast = 0;
    int            exp_dup = 0;

    logic [NE-1:0] mon_prev = '0;
    logic [LW-1:0] mon_lit = '0;

    uc_broadcaster #(
        .UC_LENGTH (1024),
        .NUM_ENGINE(NE),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ucq_empty   (ucq_empty),
        .ucq2bc      (ucq2bc),
        .bc2ucq_pop  (bc2ucq_pop),
        .flush       (flush),
        .bc2eng      (bc2eng),
        .bc2eng_valid(bc2eng_valid),
        .eng2bc_ready(eng2bc_ready),
        .busy        (busy),
        .done        (done),
        .bcast_cnt   (bcast_cnt),
        .dup_cnt     (dup_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: each new broadcast must match the next expected literal
    always @(negedge clk) begin
        if (bc2eng_valid !== '0 && mon_prev === '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL bcast_unexpected got=%h required=none", bc2eng);
            end else begin
                mon_lit = exp_q.pop_front();
                if (bc2eng !== mon_lit) begin
                    failures++;
                    $display("FAIL bcast_lit got=%h required=%h", bc2eng, mon_lit);
                end
            end
        end else if (bc2eng_valid !== '0) begin
            checks++;
            if (bc2eng !== mon_lit) begin
                failures++;
                $display("FAIL bcast_stable got=%h required=%h", bc2eng, mon_lit);
            end
        end
        mon_prev = bc2eng_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    task automatic drive_src();
        ucq_empty = (src_q.size() == 0);
        ucq2bc    = ucq_empty ? '0 : src_q[0];
    endtask

    task automatic tick();
        logic p;
        #1;
        p = bc2ucq_pop;
        @(posedge clk);
        #1;
        if (p && src_q.size() > 0) void'(src_q.pop_front());
        drive_src();
        @(negedge clk);
    endtask

    task automatic enqueue(input logic [LW-1:0] lit);
        src_q.push_back(lit);
        if (tb_seen[lit]) begin
            exp_dup++;
        end else begin
            tb_seen[lit] = 1'b1;
            exp_q.push_back(lit);
            exp_bcast++;
        end
        drive_src();
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2048; i++) tb_seen[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (bc2eng_valid !== 4'b0000) begin
            failures++;
            $display("FAIL reset_valid got=%b required=0000", bc2eng_valid);
        end
        checks++;
        if (bc2ucq_pop !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctl got=%b%b%b required=001", bc2ucq_pop, busy, done);
        end
        checks++;
        if (bcast_cnt !== 16'd0 || dup_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d/%0d required=0/0", bcast_cnt, dup_cnt);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        enqueue(11'h405);
        #1;
        checks++;
        if (bc2ucq_pop !== 1'b1) begin
            failures++;
            $display("FAIL single_pop got=%b required=1", bc2ucq_pop);
        end
        tick();
        checks++;
        if (bc2eng_valid !== 4'b1111 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_valid got=%b/%b required=1111/1", bc2eng_valid, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL single_idle got=%b%b required=01", busy, done);
        end
        checks++;
        if (bcast_cnt !== CW'(exp_bcast)) begin
            failures++;
            $display("FAIL single_cnt got=%0d required=%0d", bcast_cnt, exp_bcast);
        end
    endtask

    task automatic test_stagger();
        eng2bc_ready = 4'b0001;
        enqueue(11'h123);
        tick();
        checks++;
        if (bc2eng_valid !== 4'b1111) begin
            failures++;
            $display("FAIL stag_v0 got=%b required=1111", bc2eng_valid);
        end
        tick();
        checks++;
        if (bc2eng_valid !== 4'b1110) begin
            failures++;
            $display("FAIL stag_v1 got=%b required=1110", bc2eng_valid);
        end
        eng2bc_ready = 4'b0100;
        tick();
        checks++;
        if (bc2eng_valid !== 4'b1010 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stag_v2 got=%b/%b required=1010/1", bc2eng_valid, busy);
        end
        checks++;
        if (bcast_cnt !== CW'(exp_bcast - 1)) begin
            failures++;
            $display("FAIL stag_cnt_mid got=%0d required=%0d", bcast_cnt, exp_bcast - 1);
        end
        eng2bc_ready = 4'b1010;
        tick();
        checks++;
        if (bc2eng_valid !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stag_v3 got=%b/%b required=0000/0", bc2eng_valid, busy);
        end
        checks++;
        if (bcast_cnt !== CW'(exp_bcast)) begin
            failures++;
            $display("FAIL stag_cnt got=%0d required=%0d", bcast_cnt, exp_bcast);
        end
        eng2bc_ready = 4'b1111;
    endtask

    task automatic test_dup();
        flush = 1'b1;
        clear_model();
        tick();
        flush = 1'b0;
        enqueue(11'h005);
        enqueue(11'h005);
        enqueue(11'h405);
        enqueue(11'h005);
        tick();
        checks++;
        if (bc2eng_valid !== 4'b1111) begin
            failures++;
            $display("FAIL dup_first got=%b required=1111", bc2eng_valid);
        end
        tick();
        checks++;
        if (bc2ucq_pop !== 1'b1 || bc2eng_valid !== 4'b0000) begin
            failures++;
            $display("FAIL dup_drop1 got=%b/%b required=1/0000", bc2ucq_pop, bc2eng_valid);
        end
        tick();
        checks++;
        if (bc2ucq_pop !== 1'b1 || bc2eng_valid !== 4'b0000) begin
            failures++;
            $display("FAIL dup_next got=%b/%b required=1/0000", bc2ucq_pop, bc2eng_valid);
        end
        checks++;
        if (dup_cnt !== CW'(exp_dup - 1)) begin
            failures++;
            $display("FAIL dup_cnt_mid got=%0d required=%0d", dup_cnt, exp_dup - 1);
        end
        tick();
        checks++;
        if (bc2eng_valid !== 4'b1111) begin
            failures++;
            $display("FAIL dup_second got=%b required=1111", bc2eng_valid);
        end
        tick();
        checks++;
        if (bc2ucq_pop !== 1'b1 || bc2eng_valid !== 4'b0000) begin
            failures++;
            $display("FAIL dup_drop2 got=%b/%b required=1/0000", bc2ucq_pop, bc2eng_valid);
        end
        tick();
        checks++;
        if (done !== 1'b1 || dup_cnt !== CW'(exp_dup) || bcast_cnt !== CW'(exp_bcast)) begin
            failures++;
            $display("FAIL dup_end got=%b/%0d/%0d required=1/%0d/%0d",
                     done, dup_cnt, bcast_cnt, exp_dup, exp_bcast);
        end
    endtask

    task automatic test_flush_send();
        eng2bc_ready = 4'b0011;
        enqueue(11'h0AA);
        tick();
        checks++;
        if (bc2eng_valid !== 4'b1111) begin
            failures++;
            $display("FAIL fls_v0 got=%b required=1111", bc2eng_valid);
        end
        tick();
        checks++;
        if (bc2eng_valid !== 4'b1100) begin
            failures++;
            $display("FAIL fls_v1 got=%b required=1100", bc2eng_valid);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_model();
        exp_bcast--;
        checks++;
        if (bc2eng_valid !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fls_abort got=%b/%b required=0000/0", bc2eng_valid, busy);
        end
        checks++;
        if (bcast_cnt !== CW'(exp_bcast)) begin
            failures++;
            $display("FAIL fls_cnt got=%0d required=%0d", bcast_cnt, exp_bcast);
        end
        eng2bc_ready = 4'b1111;
        enqueue(11'h005);
        tick();
        checks++;
        if (bc2eng_valid !== 4'b1111) begin
            failures++;
            $display("FAIL fls_resend got=%b required=1111", bc2eng_valid);
        end
        tick();
        checks++;
        if (bcast_cnt !== CW'(exp_bcast)) begin
            failures++;
            $display("FAIL fls_resend_cnt got=%0d required=%0d", bcast_cnt, exp_bcast);
        end
    endtask

    task automatic test_flush_hold();
        flush = 1'b1;
        clear_model();
        enqueue(11'h300);
        enqueue(11'h301);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bc2ucq_pop !== 1'b0 || bc2eng_valid !== 4'b0000) begin
                failures++;
                $display("FAIL hold_pop[%0d] got=%b/%b required=0/0000",
                         i, bc2ucq_pop, bc2eng_valid);
            end
            tick();
        end
        flush = 1'b0;
        #1;
        checks++;
        if (bc2ucq_pop !== 1'b1) begin
            failures++;
            $display("FAIL hold_resume got=%b required=1", bc2ucq_pop);
        end
        tick();
        checks++;
        if (bc2eng_valid !== 4'b1111) begin
            failures++;
            $display("FAIL hold_v0 got=%b required=1111", bc2eng_valid);
        end
        tick();
        checks++;
        if (bc2ucq_pop !== 1'b1) begin
            failures++;
            $display("FAIL hold_pop2 got=%b required=1", bc2ucq_pop);
        end
        tick();
        tick();
        checks++;
        if (done !== 1'b1 || bcast_cnt !== CW'(exp_bcast)) begin
            failures++;
            $display("FAIL hold_end got=%b/%0d required=1/%0d", done, bcast_cnt, exp_bcast);
        end
    endtask

    task automatic test_reset_send();
        eng2bc_ready = 4'b0000;
        enqueue(11'h2FF);
        tick();
        checks++;
        if (bc2eng_valid !== 4'b1111) begin
            failures++;
            $display("FAIL rsend_v0 got=%b required=1111", bc2eng_valid);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        clear_model();
        exp_bcast = 0;
        exp_dup = 0;
        checks++;
        if (bc2eng_valid !== 4'b0000 || busy !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL rsend_state got=%b/%b/%b required=0000/0/1",
                     bc2eng_valid, busy, done);
        end
        checks++;
        if (bcast_cnt !== 16'd0 || dup_cnt !== 16'd0) begin
            failures++;
            $display("FAIL rsend_cnt got=%0d/%0d required=0/0", bcast_cnt, dup_cnt);
        end
        eng2bc_ready = 4'b1111;
        enqueue(11'h2FF);
        tick();
        checks++;
        if (bc2eng_valid !== 4'b1111) begin
            failures++;
            $display("FAIL rsend_again got=%b required=1111", bc2eng_valid);
        end
        tick();
        checks++;
        if (bcast_cnt !== CW'(exp_bcast) || dup_cnt !== 16'd0) begin
            failures++;
            $display("FAIL rsend_cnt2 got=%0d/%0d required=%0d/0",
                     bcast_cnt, dup_cnt, exp_bcast);
        end
    endtask

    initial begin
        clear_model();
        drive_src();
        @(negedge clk);
        test_reset();
        test_single();
        test_stagger();
        test_dup();
        test_flush_send();
        test_flush_hold();
        test_reset_send();
        tick();
        checks++;
        if (exp_q.size() != 0 || src_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d/%0d required=0/0", exp_q.size(), src_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
